// File: rtl/counter_modn_ctrl.sv
// ---------------------------------------------------------------------------
// counter_modn_ctrl
//
// Controllable modulo-N counter with a start/stop FSM (IDLE/RUN/DONE),
// up/down stepping, count enable, synchronous clear and clamped load,
// free-running or one-shot modes, and registered wrap/done pulses.
//
// Optional feature macro: COUNTER_MODN_WRAPCNT_EN
//   When defined, adds the wrap_cnt output: an 8-bit saturating count of
//   wrap events, cleared by rst_n and clr.
//
// Parameters:
//   N        modulus (>= 2); count ranges 0..N-1
//   W        derived width of count/load_val, max(1, $clog2(N))
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear (count=0, state=IDLE)
//   load      in   synchronous load strobe (value clamped to N-1)
//   load_val  in   value to load
//   start     in   start request (accepted in IDLE only)
//   stop      in   stop request (RUN -> IDLE)
//   oneshot   in   mode, latched when start is accepted
//   en        in   count enable, effective in RUN only
//   up        in   direction, 1 = increment, 0 = decrement
//   count     out  current count
//   wrap      out  one-cycle pulse on a modulo wrap (free-run)
//   done      out  one-cycle pulse on one-shot completion
//   busy      out  high while in RUN
//   wrap_cnt  out  saturating wrap count (COUNTER_MODN_WRAPCNT_EN only)
// ---------------------------------------------------------------------------
module counter_modn_ctrl #(
    parameter  int N = 16,
    localparam int W = (($clog2(N) < 1) ? 1 : $clog2(N))
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         done,
    output logic         busy
`ifdef COUNTER_MODN_WRAPCNT_EN
    ,
    output logic [7:0]   wrap_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Extended (W+1)-bit constants: the largest legal count and the modulus.
    localparam logic [W:0] LAST_EXT = (W+1)'(N - 1);
    localparam logic [W:0] MOD_EXT  = (W+1)'(N);
    localparam logic [W:0] ONE_EXT  = (W+1)'(1'b1);
    localparam logic [W:0] ALL1_EXT = {(W+1){1'b1}};

    state_t       state_r, state_s;
    logic         mode_r, mode_s;       // 1 = one-shot
    logic [W-1:0] count_r, count_s;
    logic         wrap_r, wrap_s;
    logic         done_r, done_s;
    logic         busy_r;

    logic [W:0]   count_ext_s;
    logic [W:0]   load_ext_s;
    logic [W:0]   inc_s;
    logic [W:0]   dec_s;
    logic         term_s;

    // Extended-width arithmetic: an increment that reaches N, or a decrement
    // that borrows past zero, is exactly a step from the terminal value.
    always_comb begin
        count_ext_s = {1'b0, count_r};
        load_ext_s  = {1'b0, load_val};
        inc_s       = count_ext_s + ONE_EXT;
        dec_s       = count_ext_s - ONE_EXT;
        if (up) begin
            term_s = (inc_s == MOD_EXT);
        end else begin
            term_s = (dec_s == ALL1_EXT);
        end
    end

    // Next-state and next-output logic; priority clr > load > stop > start > step.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        count_s = count_r;
        wrap_s  = 1'b0;
        done_s  = 1'b0;
        if (clr) begin
            count_s = {W{1'b0}};
            state_s = ST_IDLE;
        end else if (load) begin
            // DONE is always a single cycle, even when a load lands on it.
            if (state_r == ST_DONE) begin
                state_s = ST_IDLE;
            end else begin
                state_s = state_r;
            end
            if (load_ext_s > LAST_EXT) begin
                count_s = LAST_EXT[W-1:0];
            end else begin
                count_s = load_val;
            end
        end else if (stop) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_RUN;
                        mode_s  = oneshot;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (term_s) begin
                            if (mode_r) begin
                                // One-shot: hold at the terminal value.
                                state_s = ST_DONE;
                                done_s  = 1'b1;
                            end else begin
                                wrap_s = 1'b1;
                                if (up) begin
                                    count_s = {W{1'b0}};
                                end else begin
                                    count_s = LAST_EXT[W-1:0];
                                end
                            end
                        end else begin
                            if (up) begin
                                count_s = inc_s[W-1:0];
                            end else begin
                                count_s = dec_s[W-1:0];
                            end
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, mode, count and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            count_r <= {W{1'b0}};
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            count_r <= count_s;
            wrap_r  <= wrap_s;
            done_r  <= done_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign done  = done_r;
    assign busy  = busy_r;

`ifdef COUNTER_MODN_WRAPCNT_EN
    logic [7:0] wrap_cnt_r;

    // Saturating wrap-event counter, updated on the edge that raises wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt_r <= 8'd0;
        end else if (clr) begin
            wrap_cnt_r <= 8'd0;
        end else if (wrap_s && (wrap_cnt_r != 8'd255)) begin
            wrap_cnt_r <= wrap_cnt_r + 8'd1;
        end else begin
            wrap_cnt_r <= wrap_cnt_r;
        end
    end

    assign wrap_cnt = wrap_cnt_r;
`endif

endmodule

// File: tb/tb_counter_modn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_modn_ctrl
//
// Directed self-checking bench. Two instances share one set of inputs:
// a_* is N=10, b_* is N=16. Each scenario task checks only the instance it
// targets and starts from a clear so the shared stimulus does not matter.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_counter_modn_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       oneshot;
    logic       en;
    logic       up;

    logic [3:0] a_count, b_count;
    logic       a_wrap, a_done, a_busy;
    logic       b_wrap, b_done, b_busy;
`ifdef COUNTER_MODN_WRAPCNT_EN
    logic [7:0] a_wrap_cnt, b_wrap_cnt;
`endif

    int errors;
    int checks;

    counter_modn_ctrl #(.N(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .oneshot(oneshot), .en(en), .up(up),
        .count(a_count), .wrap(a_wrap), .done(a_done), .busy(a_busy)
`ifdef COUNTER_MODN_WRAPCNT_EN
        , .wrap_cnt(a_wrap_cnt)
`endif
    );

    counter_modn_ctrl #(.N(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .oneshot(oneshot), .en(en), .up(up),
        .count(b_count), .wrap(b_wrap), .done(b_done), .busy(b_busy)
`ifdef COUNTER_MODN_WRAPCNT_EN
        , .wrap_cnt(b_wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0; start = 1'b0;
        stop = 1'b0; oneshot = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({a_count, a_busy, a_wrap, a_done} !== {4'd0, 3'b000}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got count=%0d busy=%b wrap=%b done=%b want 0/0/0/0",
                         i, a_count, a_busy, a_wrap, a_done);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_count, a_busy, a_wrap, a_done} !== {4'd0, 3'b000}) begin
                errors++;
                $display("FAIL idle cyc=%0d got count=%0d busy=%b wrap=%b done=%b want 0/0/0/0",
                         i, a_count, a_busy, a_wrap, a_done);
            end
        end
`ifdef COUNTER_MODN_WRAPCNT_EN
        checks++;
        if (a_wrap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_wrap_cnt got %0d want 0", a_wrap_cnt);
        end
`endif
    endtask

    task automatic test_freerun_up();
        logic [3:0] exp_count;
        start = 1'b1; oneshot = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({a_busy, a_count} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL start got busy=%b count=%0d want busy=1 count=0", a_busy, a_count);
        end
        exp_count = 4'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_count = (exp_count == 4'd9) ? 4'd0 : exp_count + 4'd1;
            checks++;
            if ({a_count, a_wrap, a_busy} !== {exp_count, (exp_count == 4'd0), 1'b1}) begin
                errors++;
                $display("FAIL up_step %0d got count=%0d wrap=%b busy=%b want count=%0d wrap=%b busy=1",
                         i, a_count, a_wrap, a_busy, exp_count, (exp_count == 4'd0));
            end
        end
`ifdef COUNTER_MODN_WRAPCNT_EN
        checks++;
        if (a_wrap_cnt !== 8'd1) begin
            errors++;
            $display("FAIL up_wrap_cnt got %0d want 1", a_wrap_cnt);
        end
`endif
    endtask

    task automatic test_down();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({a_count, a_busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr got count=%0d busy=%b want 0/0", a_count, a_busy);
        end
        start = 1'b1; oneshot = 1'b0; up = 1'b0; en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({a_count, a_wrap} !== {4'd9, 1'b1}) begin
            errors++;
            $display("FAIL down_wrap got count=%0d wrap=%b want 9/1", a_count, a_wrap);
        end
        tick();
        checks++;
        if ({a_count, a_wrap} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL down_step got count=%0d wrap=%b want 8/0", a_count, a_wrap);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({a_count, a_busy, a_wrap} !== {4'd8, 2'b00}) begin
            errors++;
            $display("FAIL stop got count=%0d busy=%b wrap=%b want 8/0/0", a_count, a_busy, a_wrap);
        end
    endtask

    task automatic test_oneshot();
        // Expected {count, busy, done} after each edge following the start edge.
        logic [5:0] exp_tab [5];
        exp_tab[0] = {4'd14, 2'b10};
        exp_tab[1] = {4'd15, 2'b10};
        exp_tab[2] = {4'd15, 2'b01};
        exp_tab[3] = {4'd15, 2'b00};
        exp_tab[4] = {4'd15, 2'b00};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load = 1'b1; load_val = 4'd13;
        tick();
        load = 1'b0;
        checks++;
        if ({b_count, b_busy} !== {4'd13, 1'b0}) begin
            errors++;
            $display("FAIL os_load got count=%0d busy=%b want 13/0", b_count, b_busy);
        end
        start = 1'b1; oneshot = 1'b1; up = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; oneshot = 1'b0;
        checks++;
        if ({b_count, b_busy} !== {4'd13, 1'b1}) begin
            errors++;
            $display("FAIL os_start got count=%0d busy=%b want 13/1", b_count, b_busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({b_count, b_busy, b_done, b_wrap} !== {exp_tab[i], 1'b0}) begin
                errors++;
                $display("FAIL os_step %0d got count=%0d busy=%b done=%b wrap=%b want count=%0d busy=%b done=%b wrap=0",
                         i, b_count, b_busy, b_done, b_wrap, exp_tab[i][5:2], exp_tab[i][1], exp_tab[i][0]);
            end
        end
    endtask

    task automatic test_load_prio();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load = 1'b1; load_val = 4'd12;
        tick();
        load = 1'b0;
        checks++;
        if (a_count !== 4'd9) begin
            errors++;
            $display("FAIL load_clamp got count=%0d want 9", a_count);
        end
        start = 1'b1; oneshot = 1'b0; en = 1'b0;
        tick();
        start = 1'b0;
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        tick();
        clr = 1'b0; load = 1'b0;
        checks++;
        if ({a_count, a_busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr_over_load got count=%0d busy=%b want 0/0", a_count, a_busy);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle got busy=%b want 0", a_busy);
        end
        // Stop on the same edge as a terminal step: no step, no wrap.
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; start = 1'b1; oneshot = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({a_count, a_busy, a_wrap, a_done} !== {4'd9, 3'b000}) begin
            errors++;
            $display("FAIL stop_at_terminal got count=%0d busy=%b wrap=%b done=%b want 9/0/0/0",
                     a_count, a_busy, a_wrap, a_done);
        end
    endtask

    task automatic test_reset_midrun();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1; oneshot = 1'b0; up = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b_count, b_busy} !== {4'd5, 1'b1}) begin
                errors++;
                $display("FAIL en_gate cyc=%0d got count=%0d busy=%b want 5/1", i, b_count, b_busy);
            end
        end
        en = 1'b1;
        tick();
        tick();
        checks++;
        if ({b_count, b_busy} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL resume got count=%0d busy=%b want 7/1", b_count, b_busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({b_count, b_busy, b_done, b_wrap} !== {4'd0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset got count=%0d busy=%b done=%b wrap=%b want 0/0/0/0",
                     b_count, b_busy, b_done, b_wrap);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({b_count, b_busy, b_done, b_wrap} !== {4'd0, 3'b000}) begin
            errors++;
            $display("FAIL after_reset got count=%0d busy=%b done=%b wrap=%b want 0/0/0/0",
                     b_count, b_busy, b_done, b_wrap);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_freerun_up();
        test_down();
        test_oneshot();
        test_load_prio();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_modn_ctrl.md
# counter_modn_ctrl

Parametrised, controllable modulo-N counter: the next generation of the team's plain free-running mod-N counter. It adds up/down direction, count enable, synchronous clear and load, and a start/stop control FSM with free-running or one-shot modes. It emits registered wrap and done pulses. It sits beside datapath timing logic as a programmable interval/sequence counter and keeps a modulus of any N ≥ 2, including non-powers-of-two.

## Interface
- N, default 16: modulus, must be ≥ 2; count ranges 0..N-1.
- W, derived localparam: max(1, $clog2(N)); width of count and load_val.
- clk  in  1: single clock, rising-edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- clr  in  1: synchronous clear.
- load  in  1: synchronous load strobe.
- load_val  in  W: value to load.
- start  in  1: start request.
- stop  in  1: stop request.
- oneshot  in  1: mode select, sampled only when start is accepted (1 = one-shot, 0 = free-run).
- en  in  1: count enable, effective in RUN only.
- up  in  1: direction, 1 = increment, 0 = decrement.
- count  out  W: current count.
- wrap  out  1: one-cycle pulse on a modulo wrap.
- done  out  1: one-cycle pulse on one-shot completion.
- busy  out  1: high while in RUN.
- wrap_cnt  out  8: saturating wrap-event count; present only with COUNTER_MODN_WRAPCNT_EN.

## Operation
- FSM states:
  - IDLE: count holds.
  - RUN: count steps when en=1.
  - DONE: one cycle long, then always returns to IDLE.
- Transitions:
  - IDLE to RUN on start=1 and stop=0; the oneshot input is latched into a mode register.
  - RUN to IDLE on stop=1.
  - RUN to DONE on a one-shot terminal step.
  - start in RUN or DONE is ignored.
- Priority per cycle is clr > load > stop > start > step.
- clr: count=0, state=IDLE, wrap=0, done=0.
- load (not clr): the state is unchanged and no step happens that cycle.
  - load_val ≤ N-1: count = load_val.
  - load_val ≥ N: count = N-1 (clamp).
- Step in RUN with en=1:
  - Up: count+1, except N-1 goes to 0.
  - Down: count-1, except 0 goes to N-1.
- A step from a terminal value is the wrap condition. Terminal value is N-1 when counting up and 0 when counting down.
  - Free-run: count wraps and wrap pulses.
  - One-shot: count holds at the terminal value, there is no wrap pulse, the state goes to DONE and done pulses.
- Direction may change on any cycle. The terminal value is evaluated using the current up.
- en=0 in RUN: count holds and the state stays RUN.
- Arithmetic is done at W+1 bits internally, so count never leaves 0..N-1.

## Timing
- Reset (rst_n=0, asynchronous): count=0, wrap=0, done=0, busy=0, state=IDLE, mode=free-run, wrap_cnt=0. Outputs hold these values until the first rising edge after rst_n deasserts.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Start latency: start sampled at edge k gives busy=1 after edge k. The first step can occur at edge k+1.
- Step latency: en/up sampled at edge k gives the new count after edge k.
- wrap is asserted in the same cycle that count shows the wrapped value, for exactly one cycle.
- done is high exactly during the single DONE cycle, and busy=0 during that cycle. In the next cycle the state is IDLE.
- Reset mid-RUN: all state returns to reset values immediately. No done or wrap pulse is emitted.
- stop on the same edge as a terminal step: stop wins, so there is no step, no wrap and no done.

## Configuration
- COUNTER_MODN_WRAPCNT_EN defined:
  - The wrap_cnt port and its logic exist.
  - wrap_cnt increments on every edge where wrap is set and saturates at 255.
  - It clears on rst_n and clr.
  - One-shot completions do not count.
- Not defined: the wrap_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset/idle, N=10: hold rst_n=0 for 2 cycles, release, then idle 5 cycles with en=1 -> count=0, busy=0, wrap=0, done=0 throughout.
- Free-run up, N=10: start with oneshot=0, en=1, up=1 for 12 steps -> count runs 1..9, 0, 1, 2; wrap is high only on the cycle count=0; wrap_cnt=1 when the macro is defined.
- Down, N=10: from count=0, run free-run with up=0 for 2 steps -> count 9, 8; wrap pulses on the cycle count=9.
- One-shot, N=16: load 13, start with oneshot=1, up=1, en=1 -> count 14, 15, then holds at 15; done high for one cycle; busy falls with done; the state then returns to IDLE; wrap is never asserted.
- Load clamp and priority, N=10:
  - load_val=12 -> count=9.
  - clr and load together -> count=0 and state IDLE.
  - start and stop together in IDLE -> busy stays 0.
- Reset mid-run and en gating, N=16:
  - Toggle en=0 for 3 cycles during RUN -> count holds and busy stays 1.
  - Pulse rst_n low at count=7 -> count=0 and busy=0 asynchronously, with no done pulse.
